// File: rtl/stage4_memory_if.sv
// Handshake and bus bundle for the LEGv8 memory-access stage: execute input,
// data-memory port, writeback output and branch redirect.
interface stage4_memory_if #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5
);
  logic              ex_valid;
  logic              ex_ready;
  logic [DATA_W-1:0] ex_result;
  logic              ex_zero;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_W-1:0]  ex_rd;
  logic              ex_memread;
  logic              ex_memwrite;
  logic              ex_regwrite;
  logic              ex_memtoreg;
  logic              ex_branch;
  logic              ex_uncond;
  logic [DATA_W-1:0] ex_branch_target;

  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              wb_valid;
  logic              wb_ready;
  logic [DATA_W-1:0] wb_data;
  logic [REG_W-1:0]  wb_rd;
  logic              wb_regwrite;

  logic              pc_src;
  logic [DATA_W-1:0] pc_target;
  logic              misalign;

  modport slave (
    input  ex_valid, ex_result, ex_zero, ex_store_data, ex_rd, ex_memread,
           ex_memwrite, ex_regwrite, ex_memtoreg, ex_branch, ex_uncond,
           ex_branch_target, mem_ack, mem_rdata, wb_ready,
    output ex_ready, mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_data,
           wb_rd, wb_regwrite, pc_src, pc_target, misalign
  );

  modport master (
    output ex_valid, ex_result, ex_zero, ex_store_data, ex_rd, ex_memread,
           ex_memwrite, ex_regwrite, ex_memtoreg, ex_branch, ex_uncond,
           ex_branch_target, mem_ack, mem_rdata, wb_ready,
    input  ex_ready, mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_data,
           wb_rd, wb_regwrite, pc_src, pc_target, misalign
  );
endinterface

// File: rtl/stage4_memory.sv
// LEGv8 memory-access stage: issues LDUR/STUR over req/ack, resolves CBZ/B,
// and retires every bundle in order through a valid/ready writeback port.
module stage4_memory #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  stage4_memory_if.slave bus
);

  typedef enum logic {IDLE, MEM_WAIT} state_t;

  state_t            state, state_next;
  logic              ready;
  logic              accept;
  logic              is_mem;
  logic              mem_done;
  logic              take_branch;
  logic [REG_W-1:0]  rd_p1;
  logic              regwrite_p1;
  logic              load_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    ready        = (state == IDLE) && (!bus.wb_valid || bus.wb_ready);
    bus.ex_ready = ready;
    is_mem       = bus.ex_memread || bus.ex_memwrite;
    accept       = bus.ex_valid && ready;
    take_branch  = (bus.ex_branch && bus.ex_zero) || bus.ex_uncond;
    mem_done     = (state == MEM_WAIT) && bus.mem_req && bus.mem_ack;
    case (state)
      IDLE:     if (accept && is_mem) state_next = MEM_WAIT;
      MEM_WAIT: if (mem_done)         state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  // Stage p1: registered memory request, writeback bundle and redirect
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.mem_req     <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.wb_valid    <= 1'b0;
      bus.wb_data     <= '0;
      bus.wb_rd       <= '0;
      bus.wb_regwrite <= 1'b0;
      bus.pc_src      <= 1'b0;
      bus.pc_target   <= '0;
      bus.misalign    <= 1'b0;
      rd_p1           <= '0;
      regwrite_p1     <= 1'b0;
      load_p1         <= 1'b0;
    end else begin
      bus.pc_src   <= accept && take_branch;
      bus.misalign <= accept && is_mem && (bus.ex_result[2:0] != 3'b000);
      if (accept) bus.pc_target <= bus.ex_branch_target;

      // A combined read+write performs only the load
      if (accept && is_mem) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= bus.ex_memwrite && !bus.ex_memread;
        bus.mem_addr  <= {bus.ex_result[DATA_W-1:3], 3'b000};
        bus.mem_wdata <= bus.ex_store_data;
        rd_p1         <= bus.ex_rd;
        regwrite_p1   <= bus.ex_regwrite;
        load_p1       <= bus.ex_memread;
      end else if (mem_done) begin
        bus.mem_req   <= 1'b0;
      end

      // Stores retire as a zero-data, no-write marker to keep order visible
      if (accept && !is_mem) begin
        bus.wb_valid    <= 1'b1;
        bus.wb_data     <= bus.ex_result;
        bus.wb_rd       <= bus.ex_rd;
        bus.wb_regwrite <= bus.ex_regwrite;
      end else if (mem_done) begin
        bus.wb_valid    <= 1'b1;
        bus.wb_data     <= load_p1 ? bus.mem_rdata : '0;
        bus.wb_rd       <= rd_p1;
        bus.wb_regwrite <= load_p1 && regwrite_p1;
      end else if (bus.wb_ready) begin
        bus.wb_valid    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stage4_memory.sv
// Bench for stage4_memory: directed scenarios plus a randomized stream, all
// checked against a transaction-level model of retirement, memory and redirects.
module tb_stage4_memory;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stage4_memory_if #(.DATA_W(64), .REG_W(5)) bus ();

  stage4_memory #(.DATA_W(64), .REG_W(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
    logic        rw;
  } wb_t;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        we;
    logic        load;
    logic        rw;
    logic [4:0]  rd;
  } mop_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic rnd_env = 1'b0;

  wb_t         q[$];
  mop_t        pend;
  logic        busy     = 1'b0;
  logic        exp_pc   = 1'b0;
  logic [63:0] exp_tgt  = '0;
  logic        exp_mis  = 1'b0;
  logic        last_acc = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_env) begin
      bus.wb_ready  = ($urandom_range(0, 3) != 0);
      bus.mem_ack   = ($urandom_range(0, 2) == 0);
      bus.mem_rdata = {$urandom, $urandom};
    end
  endtask

  task automatic send(input logic [63:0] res, input logic [4:0] rd,
                      input logic mr, input logic mw, input logic rw,
                      input logic br, input logic un, input logic z,
                      input logic [63:0] sd, input logic [63:0] tgt);
    int n;
    bus.ex_valid         = 1'b1;
    bus.ex_result        = res;
    bus.ex_rd            = rd;
    bus.ex_memread       = mr;
    bus.ex_memwrite      = mw;
    bus.ex_regwrite      = rw;
    bus.ex_memtoreg      = mr;
    bus.ex_branch        = br;
    bus.ex_uncond        = un;
    bus.ex_zero          = z;
    bus.ex_store_data    = sd;
    bus.ex_branch_target = tgt;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 200);
    if (!last_acc) chk("send_timeout", 64'd0, 64'd1);
    bus.ex_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_req"},     bus.mem_req,     0);
    chk({tag, "_mem_we"},      bus.mem_we,      0);
    chk({tag, "_mem_addr"},    bus.mem_addr,    0);
    chk({tag, "_mem_wdata"},   bus.mem_wdata,   0);
    chk({tag, "_wb_valid"},    bus.wb_valid,    0);
    chk({tag, "_wb_data"},     bus.wb_data,     0);
    chk({tag, "_wb_rd"},       bus.wb_rd,       0);
    chk({tag, "_wb_regwrite"}, bus.wb_regwrite, 0);
    chk({tag, "_pc_src"},      bus.pc_src,      0);
    chk({tag, "_pc_target"},   bus.pc_target,   0);
    chk({tag, "_misalign"},    bus.misalign,    0);
    chk({tag, "_ex_ready"},    bus.ex_ready,    1);
  endtask

  // Reference model: in-order retirement queue plus one outstanding memory op
  always @(negedge clk) begin
    logic exp_ready, accept, is_mem, take;
    wb_t  w;
    if (!rst_n) begin
      q.delete();
      busy     = 1'b0;
      exp_pc   = 1'b0;
      exp_mis  = 1'b0;
      last_acc = 1'b0;
    end else begin
      exp_ready = !busy && (q.size() == 0 || bus.wb_ready);
      chk("ex_ready", bus.ex_ready, exp_ready);
      chk("wb_valid", bus.wb_valid, q.size() > 0);
      if (q.size() > 0) begin
        chk("wb_data",     bus.wb_data,     q[0].data);
        chk("wb_rd",       bus.wb_rd,       q[0].rd);
        chk("wb_regwrite", bus.wb_regwrite, q[0].rw);
      end
      chk("mem_req", bus.mem_req, busy);
      if (busy) begin
        chk("mem_addr",  bus.mem_addr,  pend.addr);
        chk("mem_we",    bus.mem_we,    pend.we);
        chk("mem_wdata", bus.mem_wdata, pend.wdata);
      end
      chk("pc_src", bus.pc_src, exp_pc);
      if (exp_pc) chk("pc_target", bus.pc_target, exp_tgt);
      chk("misalign", bus.misalign, exp_mis);

      if (q.size() > 0 && bus.wb_ready) void'(q.pop_front());
      if (busy && bus.mem_ack) begin
        w.data = pend.load ? bus.mem_rdata : 64'd0;
        w.rd   = pend.rd;
        w.rw   = pend.load && pend.rw;
        q.push_back(w);
        busy = 1'b0;
      end
      accept = bus.ex_valid && exp_ready;
      is_mem = bus.ex_memread || bus.ex_memwrite;
      take   = (bus.ex_branch && bus.ex_zero) || bus.ex_uncond;
      exp_pc  = accept && take;
      exp_mis = accept && is_mem && (bus.ex_result % 8 != 0);
      if (accept) exp_tgt = bus.ex_branch_target;
      if (accept && is_mem) begin
        busy       = 1'b1;
        pend.addr  = bus.ex_result - (bus.ex_result % 8);
        pend.wdata = bus.ex_store_data;
        pend.we    = bus.ex_memwrite && !bus.ex_memread;
        pend.load  = bus.ex_memread;
        pend.rw    = bus.ex_regwrite;
        pend.rd    = bus.ex_rd;
      end else if (accept) begin
        w.data = bus.ex_result;
        w.rd   = bus.ex_rd;
        w.rw   = bus.ex_regwrite;
        q.push_back(w);
      end
      last_acc = accept;
    end
  end

  initial begin
    int req_cycles;
    bus.ex_valid = 0; bus.ex_result = 0; bus.ex_zero = 0; bus.ex_store_data = 0;
    bus.ex_rd = 0; bus.ex_memread = 0; bus.ex_memwrite = 0; bus.ex_regwrite = 0;
    bus.ex_memtoreg = 0; bus.ex_branch = 0; bus.ex_uncond = 0;
    bus.ex_branch_target = 0; bus.mem_ack = 0; bus.mem_rdata = 0; bus.wb_ready = 1;

    repeat (2) tick();
    @(negedge clk);
    check_all_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // ALU stream, back-to-back
    send(64'd5, 5'd1, 0, 0, 1, 0, 0, 0, 0, 0);
    send(64'd6, 5'd2, 0, 0, 1, 0, 0, 0, 0, 0);
    send(64'd7, 5'd3, 0, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("alu3_data", bus.wb_data, 64'd7);
    chk("alu3_rd",   bus.wb_rd,   64'd3);
    repeat (2) tick();

    // Load with three request cycles
    send(64'h40, 5'd4, 1, 0, 1, 0, 0, 0, 0, 0);
    req_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin bus.mem_ack = 1; bus.mem_rdata = 64'hDEADBEEF; end
      @(negedge clk);
      if (bus.mem_req) req_cycles++;
      chk("ld_addr",  bus.mem_addr, 64'h40);
      chk("ld_we",    bus.mem_we,   0);
      chk("ld_ready", bus.ex_ready, 0);
      tick();
    end
    bus.mem_ack = 0;
    @(negedge clk);
    chk("ld_req_cycles", req_cycles,  3);
    chk("ld_req_drop",   bus.mem_req, 0);
    chk("ld_wb_data",    bus.wb_data, 64'hDEADBEEF);
    tick();

    // Misaligned store
    send(64'h13, 5'd7, 0, 1, 1, 0, 0, 0, 64'hAA, 0);
    bus.mem_ack = 1;
    @(negedge clk);
    chk("st_misalign", bus.misalign,  1);
    chk("st_addr",     bus.mem_addr,  64'h10);
    chk("st_we",       bus.mem_we,    1);
    chk("st_wdata",    bus.mem_wdata, 64'hAA);
    tick();
    bus.mem_ack = 0;
    @(negedge clk);
    chk("st_wb_valid", bus.wb_valid,    1);
    chk("st_wb_rw",    bus.wb_regwrite, 0);
    tick();

    // Writeback backpressure, then replacement without a bubble
    bus.wb_ready = 0;
    send(64'd9, 5'd5, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_hold_data", bus.wb_data,  64'd9);
      chk("bp_ready",     bus.ex_ready, 0);
      tick();
    end
    bus.wb_ready = 1;
    send(64'd10, 5'd6, 0, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("bp_next_valid", bus.wb_valid, 1);
    chk("bp_next_data",  bus.wb_data,  64'd10);
    tick();

    // Branches: taken CBZ, untaken CBZ, unconditional B
    send(64'd0, 5'd0, 0, 0, 0, 1, 0, 1, 0, 64'h100);
    @(negedge clk);
    chk("cbz_t_src", bus.pc_src,    1);
    chk("cbz_t_tgt", bus.pc_target, 64'h100);
    tick();
    @(negedge clk);
    chk("cbz_t_pulse", bus.pc_src, 0);
    tick();
    send(64'd1, 5'd0, 0, 0, 0, 1, 0, 0, 0, 64'h200);
    @(negedge clk);
    chk("cbz_nt_src", bus.pc_src, 0);
    tick();
    send(64'd1, 5'd0, 0, 0, 0, 0, 1, 0, 0, 64'h300);
    @(negedge clk);
    chk("b_src", bus.pc_src,    1);
    chk("b_tgt", bus.pc_target, 64'h300);
    tick();

    // Reset during MEM_WAIT, then a late ack
    send(64'h80, 5'd8, 1, 0, 1, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.mem_ack = 1;
    bus.mem_rdata = 64'h1234;
    @(negedge clk);
    check_all_zero("rst_mid");
    tick();
    bus.mem_ack = 0;
    @(negedge clk);
    chk("late_ack_wb",  bus.wb_valid, 0);
    chk("late_ack_req", bus.mem_req,  0);
    tick();
    send(64'd1, 5'd6, 0, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("post_rst_data", bus.wb_data, 64'd1);
    tick();

    // Randomized stream with random backpressure, ack timing and spurious acks
    rnd_env = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int kind;
      logic [63:0] r;
      repeat ($urandom_range(0, 2)) tick();
      kind = $urandom_range(0, 4);
      r = {$urandom, $urandom};
      case (kind)
        0: send(r, 5'($urandom), 0, 0, 1'($urandom), 0, 0, 1'($urandom), 0, 0);
        1: send(r, 5'($urandom), 1, 0, 1'($urandom), 0, 0, 0, 0, 0);
        2: send(r, 5'($urandom), 0, 1, 1'($urandom), 0, 0, 0, {$urandom, $urandom}, 0);
        3: send(r, 5'($urandom), 1, 1, 1'($urandom), 0, 0, 0, {$urandom, $urandom}, 0);
        default: send(r, 5'($urandom), 0, 0, 1'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), 0, {$urandom, $urandom});
      endcase
    end
    rnd_env = 1'b0;
    bus.wb_ready = 1;
    bus.mem_ack = 1;
    repeat (4) tick();
    bus.mem_ack = 0;
    repeat (4) tick();
    @(negedge clk);
    chk("drain_wb_valid", bus.wb_valid, 0);
    chk("drain_mem_req",  bus.mem_req,  0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
